// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the multiply/divide sequencer.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU decode).
package mdu_pkg;

  // Width of the latency down-counter; latencies are limited to 1..15.
  localparam int CNT_W = 4;

  // Command encodings driven by the E-stage decoder.
  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam logic [2:0] MDU_MADD  = 3'd6;
  localparam logic [2:0] MDU_MADDU = 3'd7;

  // Sequencer state encoding.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Ops that occupy the unit for the multiply latency.
  function automatic logic op_is_mul(input logic [2:0] op);
`ifdef MDU_MADD_EN
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_MADD) || (op == MDU_MADDU);
`else
    return (op == MDU_MULT) || (op == MDU_MULTU);
`endif
  endfunction

  // Ops that occupy the unit for the divide latency.
  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational arithmetic kernel (multiply, divide, div-by-zero
// flag, optional multiply-accumulate under MDU_MADD_EN).
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_valid
);

  logic        signed_op;
  logic [63:0] a64;
  logic [63:0] b64;
  logic [63:0] prod;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic        div_zero;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Multiply and divide datapaths; division works on magnitudes so that
  // truncation toward zero and the 0x80000000 / -1 case fall out naturally.
  always_comb begin
    signed_op = (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD);
    a64       = signed_op ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
    b64       = signed_op ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
    prod      = a64 * b64;

    rs_neg    = signed_op & rs_val[31];
    rt_neg    = signed_op & rt_val[31];
    rs_mag    = rs_neg ? (32'd0 - rs_val) : rs_val;
    rt_mag    = rt_neg ? (32'd0 - rt_val) : rt_val;
    div_zero  = (rt_val == 32'd0);
    q_mag     = div_zero ? 32'd0 : (rs_mag / rt_mag);
    r_mag     = div_zero ? 32'd0 : (rs_mag % rt_mag);
    quot      = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
    rem       = rs_neg ? (32'd0 - r_mag) : r_mag;
  end

`ifdef MDU_MADD_EN
  logic [63:0] acc_sum;
  // 64-bit accumulate against the architectural HI/LO at the start edge.
  always_comb begin
    acc_sum = {hi_in, lo_in} + prod;
  end
`else
  logic unused_hilo;
  assign unused_hilo = ^{hi_in, lo_in};
`endif

  // Result select by op class; only a zero divisor invalidates the result.
  always_comb begin
    res_hi    = prod[63:32];
    res_lo    = prod[31:0];
    res_valid = 1'b1;
    if (op_is_div(op)) begin
      res_hi    = rem;
      res_lo    = quot;
      res_valid = ~div_zero;
    end
`ifdef MDU_MADD_EN
    else if ((op == MDU_MADD) || (op == MDU_MADDU)) begin
      res_hi = acc_sum[63:32];
      res_lo = acc_sum[31:0];
    end
`endif
  end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: multiply/divide sequencer with fixed latency, HI/LO registers
// and the D-stage stall request. Optional macro: MDU_MADD_EN.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        use_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_valid_q, pend_valid_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;
  logic             calc_valid;
  logic             op_multi;

  mdu_calc u_calc (
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .hi_in     (hi_q),
    .lo_in     (lo_q),
    .res_hi    (calc_hi),
    .res_lo    (calc_lo),
    .res_valid (calc_valid)
  );

  assign op_multi = op_is_mul(op) | op_is_div(op);
  assign busy     = (state_q == ST_RUN);
  assign stall    = use_d & (busy | (start & op_multi));
  assign hi       = hi_q;
  assign lo       = lo_q;

  // Next-state logic: accept commands only in IDLE, count down in RUN and
  // commit the pending result on the last busy cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_valid_d = pend_valid_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    if (state_q == ST_IDLE) begin
      if (start) begin
        if (op_multi) begin
          pend_hi_d    = calc_hi;
          pend_lo_d    = calc_lo;
          pend_valid_d = calc_valid;
          cnt_d        = op_is_div(op) ? DIV_CNT : MUL_CNT;
          state_d      = ST_RUN;
        end else if (op == MDU_MTHI) begin
          hi_d = rs_val;
        end else if (op == MDU_MTLO) begin
          lo_d = rs_val;
        end
      end
    end else begin
      if (cnt_q == CNT_W'(1)) begin
        if (pend_valid_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
        cnt_d   = '0;
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // State registers; reset aborts any operation and discards pending data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pend_hi_q    <= '0;
      pend_lo_q    <= '0;
      pend_valid_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_valid_q <= pend_valid_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: table-driven bench for mdu_seq plus hand-written sequences
// for stall, reset abort and back-to-back HI/LO moves.
module tb_mdu_seq;
  import mdu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        use_d;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_total;
  int n_pass;

  mdu_seq #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .use_d   (use_d),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The hazard unit never issues a command while the unit is busy.
  always @(posedge clk) begin
    if (reset_n && start && busy)
      $error("start asserted while busy");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ihi;
    logic [31:0] ilo;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          ecyc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command for a single cycle, leaving the bench just after the edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    tick();
    start  = 1'b0;
  endtask

  // Count busy cycles after a start edge, bounded.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      tick();
    end
  endtask

  initial begin
    int cyc;
    int sc;
    n_total = 0;
    n_pass  = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    op      = MDU_MULT;
    rs_val  = '0;
    rt_val  = '0;
    use_d   = 1'b0;

    vecs[0]  = '{MDU_MULT,  32'hFFFFFFFF, 32'd2,        32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'd2,        32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{MDU_DIVU,  32'd7,        32'd0,        32'h11112222, 32'h33334444, 32'h11112222, 32'h33334444, 10};
    vecs[4]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 32'h80000000, 10};
    vecs[5]  = '{MDU_DIVU,  32'hFFFFFFF9, 32'd2,        32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000001, 32'h7FFFFFFC, 10};
    vecs[6]  = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h40000000, 32'h00000000, 5};
    vecs[8]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[9]  = '{MDU_DIV,   32'd5,        32'd0,        32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF, 10};
`ifdef MDU_MADD_EN
    vecs[10] = '{MDU_MADDU, 32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5};
    vecs[11] = '{MDU_MADD,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5};
`else
    vecs[10] = '{MDU_MADDU, 32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0};
    vecs[11] = '{MDU_MADD,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 0};
`endif

    // Reset state
    tick();
    tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    use_d = 1'b1;
    #1;
    check("reset_stall", {31'd0, stall}, 32'd0);
    use_d = 1'b0;
    reset_n = 1'b1;
    tick();

    // Table: preset HI/LO with back-to-back MTHI/MTLO, then run the op
    for (int i = 0; i < 12; i++) begin
      issue(MDU_MTHI, vecs[i].ihi, 32'd0);
      check("mthi_hi", hi, vecs[i].ihi);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      issue(MDU_MTLO, vecs[i].ilo, 32'd0);
      check("mtlo_lo", lo, vecs[i].ilo);
      check("mtlo_busy", {31'd0, busy}, 32'd0);
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      if (vecs[i].ecyc > 0) begin
        check("nobypass_hi", hi, vecs[i].ihi);
        check("nobypass_lo", lo, vecs[i].ilo);
      end
      wait_idle(cyc);
      check("busy_cycles", cyc, vecs[i].ecyc);
      check("result_hi", hi, vecs[i].ehi);
      check("result_lo", lo, vecs[i].elo);
      $display("vec %0d op=%0d rs=%08h rt=%08h -> hi=%08h lo=%08h busy=%0d", i, vecs[i].op,
               vecs[i].rs, vecs[i].rt, hi, lo, cyc);
    end

    // Stall covers the start cycle plus every busy cycle
    use_d  = 1'b1;
    start  = 1'b1;
    op     = MDU_MULT;
    rs_val = 32'd3;
    rt_val = 32'd4;
    sc     = 0;
    #1;
    if (stall) sc++;
    tick();
    start = 1'b0;
    cyc   = 0;
    while (busy && cyc < 40) begin
      cyc++;
      if (stall) sc++;
      tick();
    end
    check("stall_cycles", sc, 32'd6);
    check("stall_idle_used", {31'd0, stall}, 32'd0);
    use_d = 1'b0;
    #1;
    check("stall_idle", {31'd0, stall}, 32'd0);
    $display("stall seq: stall cycles=%0d busy=%0d", sc, cyc);

    // use_d low during a busy cycle gives no stall
    issue(MDU_DIVU, 32'd9, 32'd3);
    check("stall_nouse_busy", {31'd0, stall}, 32'd0);
    use_d = 1'b1;
    #1;
    check("stall_use_busy", {31'd0, stall}, 32'd1);
    use_d = 1'b0;
    wait_idle(cyc);
    check("divu_9_3_lo", lo, 32'd3);
    $display("divu 9/3 -> hi=%08h lo=%08h busy=%0d", hi, lo, cyc);

    // Reset mid-DIV aborts and clears everything
    issue(MDU_MTHI, 32'h0BADF00D, 32'd0);
    issue(MDU_MTLO, 32'h12345678, 32'd0);
    issue(MDU_DIV, 32'd100, 32'd7);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_abort_hi", hi, 32'd0);
    issue(MDU_MULT, 32'd3, 32'd4);
    wait_idle(cyc);
    check("post_abort_cycles", cyc, 32'd5);
    check("post_abort_lo", lo, 32'd12);
    check("post_abort_hi2", hi, 32'd0);
    $display("reset abort then mult 3x4 -> hi=%08h lo=%08h busy=%0d", hi, lo, cyc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
